generic_fifo_env_ram_fwft: RTL
==============================

# generic_fifo_env_ram_fwft

Parametrised single-clock FIFO envelope: generic FIFO control, an inferred 1r1w RAM of arbitrary depth and width, and a selectable output mode. In first-word-fall-through (FWFT) mode a 2-entry prefetch stage hides the RAM read latency; in legacy mode a read returns data one cycle later. It adds almost-full/almost-empty flags, synchronous flush and non-power-of-2 depth. It replaces fixed-size compiled-RAM FIFO envelopes in datapath buffering.

## Interface
- DAT_WIDTH, 32, data and mask width.
- NUM_OF_ENTRIES, 32, total capacity in words; any value ≥ 2, not necessarily 2^n.
- PTR_WIDTH, $clog2(NUM_OF_ENTRIES), RAM address width.
- FWFT, 1, 1 = fall-through with valid/ready; 0 = legacy read-then-data.
- AFULL_THR, NUM_OF_ENTRIES-2, almost_full asserts when entry_used ≥ AFULL_THR.
- AEMPTY_THR, 2, almost_empty asserts when entry_used ≤ AEMPTY_THR.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush; same effect as reset.
- wr_op  in  1  push request.
- wr_data  in  DAT_WIDTH  push data.
- wr_mask  in  DAT_WIDTH  per-bit enable; a bit with mask 0 is stored as 0.
- rd_op  in  1  FWFT: pop/ready; legacy: read request.
- rd_data  out  DAT_WIDTH  head word (FWFT) or returned word (legacy).
- rd_valid  out  1  FWFT: rd_data holds the head word; legacy: 1-cycle return pulse.
- full, empty, almost_full, almost_empty  out  1 each  registered status.
- entry_used  out  PTR_WIDTH+1  words held: RAM plus prefetch stage plus in-flight read.
- wr_full_err  out  1  1-cycle pulse: push while full.
- rd_empty_err  out  1  1-cycle pulse: FWFT pop while !rd_valid; legacy read while empty.

## Operation
- Reset/clr values: entry_used=0, empty=1, full=0, almost_empty=1, almost_full=(AFULL_THR==0), rd_valid=0, rd_data=0, errors=0. Pointers return to 0, prefetch stage is emptied, and any in-flight read is discarded.
- clr and reset take priority over wr_op and rd_op in the same cycle.
- A push is accepted when wr_op=1 and full=0. wr_op while full is rejected, even if a pop occurs in the same cycle, and pulses wr_full_err.
- A pop is accepted when rd_op=1 and rd_valid=1 (FWFT), or rd_op=1 and empty=0 (legacy). A rejected pop pulses rd_empty_err and changes no state.
- entry_used: +1 on an accepted push, −1 on an accepted pop, unchanged when both occur. It never exceeds NUM_OF_ENTRIES.
- Pointers wrap explicitly from NUM_OF_ENTRIES−1 to 0; no power-of-2 arithmetic.
- FWFT prefetch stage has occupancy 0/1/2 plus one in-flight flag. Rules:
  - Issue a RAM read when the RAM holds ≥1 word and occupancy + inflight − pop < 2.
  - Returned data enters the stage in order.
  - rd_data is always the oldest stage entry.
  - rd_data holds its value while rd_valid=1 and no pop occurs.
- Legacy: an accepted read issues a RAM read; rd_data updates and rd_valid pulses on the next cycle. rd_data holds its value otherwise.
- Flags are derived from next-cycle entry_used and registered.

## Timing
- FWFT, push at cycle N into an empty FIFO: empty=0 in N+1, rd_valid=1 in N+2 (2-cycle fall-through; no bypass).
- FWFT sustains one pop per cycle with continuous rd_op once the stage holds 2 words. Concurrent push and pop run at one each per cycle.
- Legacy: read accepted in cycle N gives rd_data/rd_valid in N+1.
- Status and error outputs are registered and reflect the operations of the previous cycle.

## Structure
- Package generic_fifo_pkg: ptr-increment-with-wrap function and mode constants FIFO_MODE_FWFT/FIFO_MODE_LEGACY.
- Sub-module generic_ram_1r1w (DAT_WIDTH, NUM_OF_ENTRIES): synchronous write with bit mask, registered read with 1-cycle latency.
- Top level holds pointers, counter, flags, error pulses and the FWFT prefetch stage (a generate on FWFT).

## Test plan
- Reset then 5 pushes (0x1..0x5), FWFT: rd_valid rises 2 cycles after the first push, rd_data=0x1, entry_used=5, almost_empty=0.
- NUM_OF_ENTRIES=5: push 5 words then a 6th → full=1, wr_full_err pulse, entry_used=5. Pop/push 12 times each → data order preserved across pointer wrap.
- FWFT continuous: 32 pushes, then rd_op held high for 32 cycles → one word per cycle after the 2-cycle start, empty=1 after the last pop, no rd_empty_err.
- Legacy mode: read on empty → rd_empty_err pulse. Push 0xA5A5A5A5 with mask 0x0000FFFF, then read → rd_data=0x0000A5A5 on the next cycle with a rd_valid pulse.
- Full FIFO, simultaneous wr_op+rd_op → pop accepted, push rejected, wr_full_err=1, entry_used=NUM−1.
- clr asserted mid-stream with a read in flight → next cycle entry_used=0, rd_valid=0, empty=1. A following push appears correctly with no stale word.

Source files
------------

// File: rtl/generic_fifo_pkg.sv
// Shared constants and pointer helper for the generic FIFO envelope.
// Pointers wrap explicitly at the configured depth, so non-power-of-2 depths work.
package generic_fifo_pkg;

  localparam bit FIFO_MODE_FWFT   = 1'b1;
  localparam bit FIFO_MODE_LEGACY = 1'b0;

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/generic_ram_1r1w.sv
// Inferred simple dual-port RAM: masked synchronous write, registered read.
// The read register clears on reset so a flush also drops any in-flight word.
module generic_ram_1r1w #(
  parameter int DAT_WIDTH      = 32,
  parameter int NUM_OF_ENTRIES = 32,
  parameter int PTR_WIDTH      = $clog2(NUM_OF_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 i_srst,
  input  logic                 i_we,
  input  logic [PTR_WIDTH-1:0] i_waddr,
  input  logic [DAT_WIDTH-1:0] i_wdata,
  input  logic [DAT_WIDTH-1:0] i_wmask,
  input  logic                 i_re,
  input  logic [PTR_WIDTH-1:0] i_raddr,
  output logic [DAT_WIDTH-1:0] o_rdata
);

  logic [DAT_WIDTH-1:0] r_mem [NUM_OF_ENTRIES];
  logic [DAT_WIDTH-1:0] r_rdata;

  // Masked-off bits are stored as zero rather than preserved.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata & i_wmask;
  end

  always_ff @(posedge clk) begin
    if (i_srst)    r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/generic_fifo_env_ram_fwft.sv
// Single-clock FIFO envelope around a 1r1w RAM with FWFT or legacy read port.
// entry_used counts every word held: RAM, prefetch stage and the in-flight read.
module generic_fifo_env_ram_fwft
  import generic_fifo_pkg::*;
#(
  parameter int DAT_WIDTH      = 32,
  parameter int NUM_OF_ENTRIES = 32,
  parameter int PTR_WIDTH      = $clog2(NUM_OF_ENTRIES),
  parameter bit FWFT           = 1'b1,
  parameter int AFULL_THR      = NUM_OF_ENTRIES - 2,
  parameter int AEMPTY_THR     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clr,
  input  logic                 wr_op,
  input  logic [DAT_WIDTH-1:0] wr_data,
  input  logic [DAT_WIDTH-1:0] wr_mask,
  input  logic                 rd_op,
  output logic [DAT_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 full,
  output logic                 empty,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   entry_used,
  output logic                 wr_full_err,
  output logic                 rd_empty_err
);

  localparam int CW = PTR_WIDTH + 1;
  localparam logic [PTR_WIDTH:0] NUM_L    = CW'(NUM_OF_ENTRIES);
  localparam logic [PTR_WIDTH:0] AFULL_L  = CW'(AFULL_THR);
  localparam logic [PTR_WIDTH:0] AEMPTY_L = CW'(AEMPTY_THR);

  logic                 w_srst;
  logic [PTR_WIDTH-1:0] r_wptr, r_rptr;
  logic [PTR_WIDTH:0]   r_used, r_ram_cnt, w_used_next, w_ram_next;
  logic                 r_full, r_empty, r_afull, r_aempty, r_wfe, r_ree, r_inflight;
  logic                 w_push, w_pop, w_rd_ok, w_rd_issue, w_rd_valid;
  logic [DAT_WIDTH-1:0] w_ram_q, w_rd_data;

  assign w_srst = reset | clr;
  assign w_push = wr_op & ~r_full;
  assign w_pop  = rd_op & w_rd_ok;

  always_comb begin
    w_used_next = r_used;
    w_ram_next  = r_ram_cnt;
    if (w_push && !w_pop)      w_used_next = r_used + CW'(1);
    else if (w_pop && !w_push) w_used_next = r_used - CW'(1);
    if (w_push && !w_rd_issue)      w_ram_next = r_ram_cnt + CW'(1);
    else if (w_rd_issue && !w_push) w_ram_next = r_ram_cnt - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_srst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_used     <= '0;
      r_ram_cnt  <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_afull    <= (AFULL_L == '0);
      r_aempty   <= 1'b1;
      r_wfe      <= 1'b0;
      r_ree      <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      if (w_push)     r_wptr <= PTR_WIDTH'(ptr_inc(32'(r_wptr), NUM_OF_ENTRIES));
      if (w_rd_issue) r_rptr <= PTR_WIDTH'(ptr_inc(32'(r_rptr), NUM_OF_ENTRIES));
      r_used     <= w_used_next;
      r_ram_cnt  <= w_ram_next;
      r_full     <= (w_used_next == NUM_L);
      r_empty    <= (w_used_next == '0);
      r_afull    <= (w_used_next >= AFULL_L);
      r_aempty   <= (w_used_next <= AEMPTY_L);
      r_wfe      <= wr_op & r_full;
      r_ree      <= rd_op & ~w_rd_ok;
      r_inflight <= w_rd_issue;
    end
  end

  generic_ram_1r1w #(
    .DAT_WIDTH     (DAT_WIDTH),
    .NUM_OF_ENTRIES(NUM_OF_ENTRIES),
    .PTR_WIDTH     (PTR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .i_srst (w_srst),
    .i_we   (w_push),
    .i_waddr(r_wptr),
    .i_wdata(wr_data),
    .i_wmask(wr_mask),
    .i_re   (w_rd_issue),
    .i_raddr(r_rptr),
    .o_rdata(w_ram_q)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // The RAM output register acts as the youngest stage slot while a read lands.
      logic [1:0]           r_occ, w_occ_next;
      logic [DAT_WIDTH-1:0] r_stage0, r_stage1, w_e0, w_e1;

      assign w_e0       = (r_occ != 2'd0) ? r_stage0 : w_ram_q;
      assign w_e1       = (r_occ == 2'd2) ? r_stage1 : w_ram_q;
      assign w_rd_valid = (r_occ != 2'd0) | r_inflight;
      assign w_rd_ok    = w_rd_valid;
      assign w_rd_data  = w_e0;
      assign w_occ_next = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      assign w_rd_issue = (r_ram_cnt != '0) && (w_occ_next < 2'd2);

      always_ff @(posedge clk) begin
        if (w_srst) begin
          r_occ    <= 2'd0;
          r_stage0 <= '0;
          r_stage1 <= '0;
        end else begin
          r_occ    <= w_occ_next;
          r_stage0 <= w_pop ? w_e1 : w_e0;
          r_stage1 <= w_e1;
        end
      end
    end else begin : g_legacy
      assign w_rd_valid = r_inflight;
      assign w_rd_ok    = ~r_empty;
      assign w_rd_data  = w_ram_q;
      assign w_rd_issue = w_pop;
    end
  endgenerate

  assign rd_data      = w_rd_data;
  assign rd_valid     = w_rd_valid;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign entry_used   = r_used;
  assign wr_full_err  = r_wfe;
  assign rd_empty_err = r_ree;

endmodule
